wb_target_mem: RTL and testbench

//  Wishbone classic-cycle target (responder): a word-addressed on-chip RAM that

---
 rtl/wb_target_mem_pkg.sv | 12 +
 rtl/wb_target_mem_if.sv | 25 ++
 rtl/wb_target_mem_ram.sv | 26 ++
 rtl/wb_target_mem.sv | 124 ++++++++++++
 tb/tb_wb_target_mem.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/wb_target_mem_pkg.sv
// Shared types and constants for the Wishbone RAM target.
package wb_target_mem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_target_mem_if.sv
// Wishbone classic target-side bus bundle.
interface wb_target_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   t_adr;
    logic [DW-1:0]   t_dat_w;
    logic [DW-1:0]   t_dat_r;
    logic            t_cyc;
    logic            t_stb;
    logic            t_we;
    logic [DW/8-1:0] t_sel;
    logic            t_ack;
    logic            t_err;

    modport master (
        output t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel,
        input  t_dat_r, t_ack, t_err
    );

    modport slave (
        input  t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel,
        output t_dat_r, t_ack, t_err
    );
endinterface

// File: rtl/wb_target_mem_ram.sv
// Single-port synchronous RAM with per-byte write enables and registered read.
module wb_target_mem_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DW         = 32
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic [DW/8-1:0]       i_be,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DW-1:0]         i_wdata,
    output logic [DW-1:0]         o_rdata
);
    logic [DW-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    // Read-before-write: a write access returns the previous word.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            o_rdata <= r_mem[i_addr];
            for (int b = 0; b < DW/8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: rtl/wb_target_mem.sv
// Wishbone classic target: word-addressed RAM with wait states and range error.
module wb_target_mem
    import wb_target_mem_pkg::*;
#(
    parameter int                       WB_ADDR_WIDTH  = 32,
    parameter int                       WB_DATA_WIDTH  = 32,
    parameter int                       MEM_DEPTH_LOG2 = 10,
    parameter int                       WAIT_STATES    = 1,
    parameter logic [WB_ADDR_WIDTH-1:0] T_ADR_MASK     = 32'h0FFF_FFFF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    wb_target_mem_if.slave  bus
);
    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int DL = MEM_DEPTH_LOG2;
    localparam int BW = DW / 8;
    localparam logic [AW-1:0]    MEM_BYTES = AW'(1) << (DL + 2);
    localparam logic [CNT_W-1:0] CNT_INIT  = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [DL-1:0]    r_idx;
    logic             r_we;
    logic [BW-1:0]    r_sel;
    logic [DW-1:0]    r_dat_w;
    logic             r_err_flag;
    logic             r_ack, r_err;

    logic [AW-1:0]    w_off;
    logic [DL-1:0]    w_idx;
    logic             w_req, w_range_err, w_from_idle, w_err_eff;
    logic             w_ack_next, w_err_next, w_ram_en;
    logic [DL-1:0]    w_ram_addr;
    logic [BW-1:0]    w_ram_be;
    logic [DW-1:0]    w_ram_wdata, w_ram_rdata;

    assign w_off       = bus.t_adr & T_ADR_MASK;
    assign w_idx       = w_off[DL+1:2];
    assign w_req       = bus.t_cyc & bus.t_stb;
    assign w_range_err = (w_off >= MEM_BYTES);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES > 0) begin
                        w_state_next = WAIT;
                        w_cnt_next   = CNT_INIT;
                    end else begin
                        w_state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (!bus.t_cyc) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == '0) begin
                    w_state_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // With zero wait states the request goes straight from the bus to the RAM.
    assign w_from_idle = (r_state == IDLE);
    assign w_err_eff   = w_from_idle ? w_range_err : r_err_flag;
    assign w_ack_next  = (w_state_next == RESP) & ~w_err_eff;
    assign w_err_next  = (w_state_next == RESP) &  w_err_eff;
    assign w_ram_en    = i_rst_n & w_ack_next;
    assign w_ram_addr  = w_from_idle ? w_idx : r_idx;
    assign w_ram_be    = w_from_idle ? (bus.t_sel & {BW{bus.t_we}}) : (r_sel & {BW{r_we}});
    assign w_ram_wdata = w_from_idle ? bus.t_dat_w : r_dat_w;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_dat_w    <= '0;
            r_err_flag <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= w_ack_next;
            r_err   <= w_err_next;
            if (w_from_idle && w_req) begin
                r_idx      <= w_idx;
                r_we       <= bus.t_we;
                r_sel      <= bus.t_sel;
                r_dat_w    <= bus.t_dat_w;
                r_err_flag <= w_range_err;
            end
        end
    end

    wb_target_mem_ram #(
        .DEPTH_LOG2 (DL),
        .DW         (DW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_en    (w_ram_en),
        .i_be    (w_ram_be),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign bus.t_ack   = r_ack;
    assign bus.t_err   = r_err;
    assign bus.t_dat_r = r_ack ? w_ram_rdata : '0;
endmodule

// File: tb/tb_wb_target_mem.sv
// Directed bench for wb_target_mem at 0, 1 and 3 wait states.
module tb_wb_target_mem;
    logic        clk;
    logic        rst_n;
    logic [31:0] m_adr, m_dat_w;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    int          dsel;
    logic        ob_ack, ob_err;
    logic [31:0] ob_dat;

    int n_checks = 0;
    int n_pass   = 0;
    int both_hi  = 0;

    wb_target_mem_if #(.AW(32), .DW(32)) bus0 ();
    wb_target_mem_if #(.AW(32), .DW(32)) bus1 ();
    wb_target_mem_if #(.AW(32), .DW(32)) bus2 ();

    wb_target_mem #(.WAIT_STATES(1)) u_dut_ws1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
    wb_target_mem #(.WAIT_STATES(3)) u_dut_ws3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
    wb_target_mem #(.WAIT_STATES(0)) u_dut_ws0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

    assign bus0.t_adr = m_adr;  assign bus0.t_dat_w = m_dat_w;
    assign bus0.t_we  = m_we;   assign bus0.t_sel   = m_sel;
    assign bus0.t_cyc = m_cyc && (dsel == 0);
    assign bus0.t_stb = m_stb && (dsel == 0);
    assign bus1.t_adr = m_adr;  assign bus1.t_dat_w = m_dat_w;
    assign bus1.t_we  = m_we;   assign bus1.t_sel   = m_sel;
    assign bus1.t_cyc = m_cyc && (dsel == 1);
    assign bus1.t_stb = m_stb && (dsel == 1);
    assign bus2.t_adr = m_adr;  assign bus2.t_dat_w = m_dat_w;
    assign bus2.t_we  = m_we;   assign bus2.t_sel   = m_sel;
    assign bus2.t_cyc = m_cyc && (dsel == 2);
    assign bus2.t_stb = m_stb && (dsel == 2);

    always_comb begin
        ob_ack = bus0.t_ack;
        ob_err = bus0.t_err;
        ob_dat = bus0.t_dat_r;
        if (dsel == 1) begin
            ob_ack = bus1.t_ack; ob_err = bus1.t_err; ob_dat = bus1.t_dat_r;
        end else if (dsel == 2) begin
            ob_ack = bus2.t_ack; ob_err = bus2.t_err; ob_dat = bus2.t_dat_r;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        else n_pass++;
    endtask

    // One bus transfer; lat counts sample points from request launch to response.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic ack, output logic err,
                        output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat_w = dat; m_sel = sel;
        lat = 0; ack = 1'b0; err = 1'b0; rd = '0;
        while (!(ack || err) && lat < 20) begin
            @(negedge clk);
            lat++;
            ack = ob_ack; err = ob_err; rd = ob_dat;
            if (ob_ack && ob_err) both_hi++;
        end
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0;
        $display("dut%0d %s adr=0x%08h wdat=0x%08h sel=%b -> ack=%b err=%b rdat=0x%08h lat=%0d",
                 dsel, we ? "WR" : "RD", adr, dat, sel, ack, err, rd, lat);
    endtask

    logic        a, e;
    logic [31:0] d;
    int          lat;
    logic [31:0] model [0:7];
    logic [31:0] wv;
    logic [3:0]  ws;
    int          seen;

    initial begin
        rst_n = 1'b0; dsel = 0;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h1000_0010;
        m_dat_w = '0; m_sel = 4'hF;

        // Reset held with a live request
        repeat (3) @(negedge clk);
        check_eq("rst_ack", {31'b0, ob_ack}, 32'd0);
        check_eq("rst_err", {31'b0, ob_err}, 32'd0);
        check_eq("rst_dat", ob_dat, 32'd0);
        rst_n = 1'b1;
        lat = 0; a = 1'b0;
        while (!a && lat < 20) begin
            @(negedge clk); lat++; a = ob_ack;
        end
        check_eq("rst_first_ack_lat", lat, 32'd2);
        @(posedge clk); #1; m_cyc = 1'b0; m_stb = 1'b0;
        $display("dut0 RD after reset release -> ack=%b lat=%0d", a, lat);

        // Write then read, one wait state
        xfer(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, a, e, d, lat);
        check_eq("wr_ack", {31'b0, a}, 32'd1);
        check_eq("wr_lat", lat, 32'd3);
        xfer(1'b0, 32'h1000_0010, 32'h0, 4'hF, a, e, d, lat);
        check_eq("rd_dat", d, 32'hDEAD_BEEF);
        check_eq("rd_lat", lat, 32'd3);

        // Byte lanes
        xfer(1'b1, 32'h1000_0010, 32'h1122_3344, 4'b0101, a, e, d, lat);
        xfer(1'b0, 32'h1000_0010, 32'h0, 4'hF, a, e, d, lat);
        check_eq("lane_dat", d, 32'hDE22_BE44);
        xfer(1'b0, 32'hF000_0010, 32'h0, 4'hF, a, e, d, lat);
        check_eq("mask_dat", d, 32'hDE22_BE44);

        // Range boundaries
        xfer(1'b1, 32'h1000_0000, 32'h0102_0304, 4'hF, a, e, d, lat);
        xfer(1'b1, 32'h1000_0FFC, 32'hA5A5_5A5A, 4'hF, a, e, d, lat);
        check_eq("last_word_err", {31'b0, e}, 32'd0);
        xfer(1'b0, 32'h1000_0FFC, 32'h0, 4'hF, a, e, d, lat);
        check_eq("last_word_dat", d, 32'hA5A5_5A5A);
        xfer(1'b0, 32'h1000_1000, 32'h0, 4'hF, a, e, d, lat);
        check_eq("oor_rd_err", {31'b0, e}, 32'd1);
        check_eq("oor_rd_ack", {31'b0, a}, 32'd0);
        check_eq("oor_rd_dat", d, 32'd0);
        @(negedge clk);
        check_eq("oor_err_one_cycle", {31'b0, ob_err}, 32'd0);
        xfer(1'b1, 32'h1000_1000, 32'h5555_5555, 4'hF, a, e, d, lat);
        check_eq("oor_wr_err", {31'b0, e}, 32'd1);
        xfer(1'b0, 32'h1000_0000, 32'h0, 4'hF, a, e, d, lat);
        check_eq("oor_wr_nochange", d, 32'h0102_0304);

        // Abort during the second wait cycle, three wait states
        dsel = 1;
        xfer(1'b1, 32'h1000_0020, 32'h1234_5678, 4'hF, a, e, d, lat);
        check_eq("ws3_wr_lat", lat, 32'd5);
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h1000_0020;
        m_dat_w = 32'hCAFE_F00D; m_sel = 4'hF;
        @(posedge clk);
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ob_ack || ob_err) seen++;
        end
        $display("dut1 WR aborted adr=0x10000020 -> responses seen=%0d", seen);
        check_eq("abort_no_resp", seen, 32'd0);
        xfer(1'b0, 32'h1000_0020, 32'h0, 4'hF, a, e, d, lat);
        check_eq("abort_old_val", d, 32'h1234_5678);

        // Zero wait states: populate, then back-to-back reads with stb held
        dsel = 2;
        for (int k = 0; k < 8; k++) begin
            wv = 32'h0101_0101 * (k + 1) ^ 32'hF00D_0000;
            ws = (k % 3 == 0) ? 4'b0011 : 4'hF;
            model[k] = 32'hFFFF_FFFF;
            xfer(1'b1, 32'h1000_0100 + k * 4, 32'hFFFF_FFFF, 4'hF, a, e, d, lat);
            xfer(1'b1, 32'h1000_0100 + k * 4, wv, ws, a, e, d, lat);
            for (int b = 0; b < 4; b++) if (ws[b]) model[k][b*8 +: 8] = wv[b*8 +: 8];
        end
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF; m_adr = 32'h1000_0100;
        for (int k = 0; k < 8; k++) begin
            lat = 0; a = 1'b0; e = 1'b0;
            while (!(a || e) && lat < 10) begin
                @(negedge clk); lat++;
                a = ob_ack; e = ob_err; d = ob_dat;
                if (ob_ack && ob_err) both_hi++;
            end
            $display("dut2 RD b2b #%0d adr=0x%08h -> ack=%b err=%b rdat=0x%08h gap=%0d",
                     k, m_adr, a, e, d, lat);
            check_eq($sformatf("b2b_dat%0d", k), d, model[k]);
            check_eq($sformatf("b2b_gap%0d", k), lat, 32'd2);
            @(posedge clk); #1;
            if (k < 7) m_adr = 32'h1000_0100 + (k + 1) * 4;
            else begin m_cyc = 1'b0; m_stb = 1'b0; end
        end
        check_eq("ack_err_exclusive", both_hi, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
